// File: rtl/nonconsecutive_monitor.sv
// nonconsecutive_monitor: recognises N_A gap-separated A symbols followed by C, flags protocol violations
module nonconsecutive_monitor #(
    parameter int N_A     = 2,
    parameter int MIN_GAP = 1,
    parameter int MAX_GAP = 7
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_valid,
    input  logic [1:0] i_symbol,
    output logic       o_busy,
    output logic       o_match,
    output logic       o_error,
    output logic [1:0] o_err_code,
    output logic       o_err_seen,
    output logic [7:0] o_match_count
);
    localparam int GW = $clog2(MAX_GAP + 2);
    localparam logic [1:0] SYM_NONE = 2'b00, SYM_A = 2'b01, SYM_B = 2'b10, SYM_C = 2'b11;
    localparam logic [1:0] GAP_LONG = 2'd0, GAP_SHORT = 2'd1, UNEXPECTED = 2'd2, ABORT = 2'd3;
    typedef enum logic [1:0] {IDLE, SEEK_A, EXPECT_C} state_t;
    state_t state, nxt_state;
    logic [3:0] a_cnt, nxt_a, a_inc;
    logic [GW-1:0] gap_cnt, nxt_gap, gap_inc;
    logic err, match;
    logic [1:0] code;
    always_comb begin
        a_inc   = a_cnt + 4'd1;
        gap_inc = (gap_cnt == GW'(MAX_GAP + 1)) ? gap_cnt : gap_cnt + 1'b1;
        nxt_state = state;
        nxt_a     = a_cnt;
        nxt_gap   = gap_cnt;
        err       = 1'b0;
        match     = 1'b0;
        code      = GAP_LONG;
        case (state)
            IDLE: if (i_valid && i_symbol == SYM_A) begin
                nxt_state = SEEK_A;
                nxt_a     = 4'd1;
                nxt_gap   = '0;
            end
            SEEK_A: begin
                if (!i_valid || i_symbol == SYM_NONE) begin
                    err  = 1'b1;
                    code = ABORT;
                end else if (i_symbol == SYM_B) begin
                    err     = gap_inc > GW'(MAX_GAP);
                    code    = GAP_LONG;
                    nxt_gap = gap_inc;
                end else if (i_symbol == SYM_A) begin
                    err       = gap_cnt < GW'(MIN_GAP);
                    code      = GAP_SHORT;
                    nxt_a     = a_inc;
                    nxt_gap   = '0;
                    nxt_state = (a_inc == 4'(N_A)) ? EXPECT_C : SEEK_A;
                end else begin
                    err  = 1'b1;
                    code = UNEXPECTED;
                end
            end
            EXPECT_C: begin
                match = i_valid && i_symbol == SYM_C;
                err   = !match;
                code  = (!i_valid || i_symbol == SYM_NONE) ? ABORT : UNEXPECTED;
            end
            default: nxt_state = IDLE;
        endcase
        if (err || match) begin
            nxt_state = IDLE;
            nxt_a     = '0;
            nxt_gap   = '0;
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state         <= IDLE;
            a_cnt         <= '0;
            gap_cnt       <= '0;
            o_busy        <= 1'b0;
            o_match       <= 1'b0;
            o_error       <= 1'b0;
            o_err_code    <= 2'd0;
            o_err_seen    <= 1'b0;
            o_match_count <= 8'd0;
        end else begin
            state      <= nxt_state;
            a_cnt      <= nxt_a;
            gap_cnt    <= nxt_gap;
            o_busy     <= nxt_state != IDLE;
            o_match    <= match;
            o_error    <= err;
            o_err_seen <= o_err_seen | err;
            if (err)
                o_err_code <= code;
            if (match && o_match_count != 8'hFF)
                o_match_count <= o_match_count + 8'd1;
        end
    end
endmodule
